junction_scheduler: RTL and testbench
=====================================

# junction_scheduler

Four-way junction phase scheduler: grants green to one road at a time, using round-robin order weighted by road density. Green time is set by each road's 3-bit density sensor, empty roads are skipped, and emergency requests pre-empt the normal order. It sits between the road density sensors and the four signal-head drivers. It drives the per-road light codes and the one-hot cycle indicator consumed by the rest of the traffic-control design.

## Interface
Parameters:
- T_LESS, 4: green cycles granted to a LESS road
- T_MORE, 8: green cycles granted to a MORE road
- T_FULL, 12: green cycles granted to a FULL road
- T_MIN, 2: minimum green cycles before early termination is allowed
- T_YELLOW, 2: yellow cycles
- T_ALLRED, 1: all-red clearance cycles
- CW, 4: phase counter width; must hold max(T_FULL, T_YELLOW, T_ALLRED)

Ports:
- clock  in  1  single system clock; all state changes on rising edge
- clear  in  1  reset, asynchronous, active-low
- S1..S4  in  3  density sensors, road 1..4: 000 EMPTY, 001 LESS, 011 MORE, 111 FULL
- E  in  4  emergency request per road, bit i-1 = road i, level-sensitive
- T1..T4  out  2  light for road 1..4: 00 RED, 01 YELLOW, 10 GREEN; 11 never driven
- T  out  4  one-hot road currently green or yellow (bit i-1 = road i); 0000 during all-red

## Operation
- Sensor decode is thermometer by highest set bit:
  - bit2 set: FULL
  - else bit1 set: MORE
  - else bit0 set: LESS
  - else EMPTY
  - Non-canonical codes therefore decode deterministically.
- State machine states: ALL_RED, GREEN, YELLOW. A down-counter times each state. A 2-bit pointer `cur` holds the last granted road.
- ALL_RED: every T_i = RED and T = 0000. On its last cycle the scheduler selects the next road:
  - If any E bit is set, select the lowest-index requesting road, regardless of its density.
  - Otherwise, search cur+1, cur+2, cur+3, cur (mod 4) for the first non-EMPTY road.
  - If a road is found, go to GREEN for that road and load the green duration D.
    - D = T_FULL, T_MORE or T_LESS by the decoded density sampled at that edge.
    - An emergency grant on an EMPTY road uses T_LESS.
  - If no road is found, stay in ALL_RED and re-evaluate every cycle.
- GREEN(r): T_r = GREEN, all other roads RED, T = one-hot(r), cur = r. The state ends after D cycles, then goes to YELLOW. The state ends early when either condition below holds:
  - Early termination: S_r decodes EMPTY, at least T_MIN green cycles have elapsed, and E[r] is low.
  - Pre-emption: some E[j] with j ≠ r is asserted and E[r] is low. The state goes to YELLOW on the next edge, with no T_MIN guarantee.
- Emergency hold: while E[r] is asserted in GREEN(r), the counter is frozen and green persists. When E[r] drops, the countdown resumes from the frozen value.
- YELLOW(r): T_r = YELLOW, T = one-hot(r). It lasts T_YELLOW cycles, is never shortened or extended, then goes to ALL_RED.
- Density changes during GREEN do not alter D. Only the EMPTY early-termination rule applies.

## Timing
- Reset (clear low, asynchronous): state ALL_RED, counter loaded with T_ALLRED, cur = 3 (so road 1 is searched first), all T_i = RED, T = 0000. Outputs change immediately on reset assertion.
- All outputs are registered. A state entered at edge k shows its outputs from edge k onward.
- Durations are exact: GREEN lasts D cycles, YELLOW lasts T_YELLOW cycles, ALL_RED lasts T_ALLRED cycles (minimum).
- Full phase period for road r = D + T_YELLOW + T_ALLRED cycles.
- Selection and D both sample S/E at the final ALL_RED edge. Sensor or E changes within a cycle of that edge take effect at the next decision.
- Exactly one road is non-RED at any time. GREEN is never adjacent to another road's GREEN without YELLOW then ALL_RED in between.
- Reset mid-phase aborts immediately to ALL_RED, and the next grant again searches from road 1.
- Simultaneous early termination and pre-emption: go to YELLOW, a single transition.
- E asserted for the current road while in YELLOW: no effect. That road is re-selected at the next ALL_RED decision if its E is still high.

## Test plan
- Reset, then S1=FULL, S2=MORE, S3=MORE, S4=MORE held, E=0. Required sequence:
  - 1 cycle all-red
  - T1 GREEN 12 cycles, YELLOW 2, all-red 1
  - T2 GREEN 8 cycles, then T3 8 cycles, then T4 8 cycles
  - back to T1; T tracks the road one-hot throughout
- All sensors EMPTY for 20 cycles: T = 0000 and all RED throughout. Set S3=LESS: T3 GREEN for 4 cycles, starting the cycle after the next edge.
- S2=EMPTY, other roads MORE: order 1, 3, 4, 1, and road 2 never leaves RED.
- T1 green (FULL), S1 goes EMPTY at green cycle 1: green ends after exactly T_MIN=2 cycles, then YELLOW 2.
- T1 green (FULL) at cycle 3, pulse E[2] high and hold it:
  - T1 YELLOW next edge (2 cycles), all-red 1, then T3 GREEN
  - T3 GREEN persists while E[2] is high, even with S3=EMPTY
  - drop E[2]: T3 finishes its remaining T_LESS count
  - next road is 4
- Assert clear low mid-GREEN of road 3: all outputs RED and T=0000 immediately. On release, the first grant goes to road 1 after 1 all-red cycle.

Source files
------------

// File: rtl/junction_scheduler.sv
// Four-way junction phase scheduler: density-weighted round-robin
// green grants with emergency pre-emption and early termination.
module junction_scheduler #(
  parameter int T_LESS   = 4,
  parameter int T_MORE   = 8,
  parameter int T_FULL   = 12,
  parameter int T_MIN    = 2,
  parameter int T_YELLOW = 2,
  parameter int T_ALLRED = 1,
  parameter int CW       = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [2:0] S1,
  input  logic [2:0] S2,
  input  logic [2:0] S3,
  input  logic [2:0] S4,
  input  logic [3:0] E,
  output logic [1:0] T1,
  output logic [1:0] T2,
  output logic [1:0] T3,
  output logic [1:0] T4,
  output logic [3:0] T
);

  typedef enum logic [1:0] {
    ALL_RED,
    GREEN,
    YELLOW
  } state_t;

  typedef enum logic [1:0] {
    EMPTY,
    LESS,
    MORE,
    FULL
  } dens_t;

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] el, el_n;
  logic [1:0]    cur, cur_n;

  dens_t         d [4];
  logic          found;
  logic [1:0]    sel;
  logic [1:0]    idx;
  logic [3:0]    cur_oh;
  logic          hold;
  logic          pre;
  logic          early;
  logic [CW:0]   el_p1;
  logic [CW-1:0] el_inc;
  logic [1:0]    lt_n;
  logic [3:0]    oh_n;

  // Highest set bit wins, so non-canonical codes still decode.
  function automatic dens_t dec(input logic [2:0] s);
    dens_t r;
    r = EMPTY;
    priority case (1'b1)
      s[2]:    r = FULL;
      s[1]:    r = MORE;
      s[0]:    r = LESS;
      default: r = EMPTY;
    endcase
    return r;
  endfunction

  function automatic logic [CW-1:0] dur(input dens_t x);
    logic [CW-1:0] v;
    v = CW'(T_LESS);
    unique case (x)
      FULL:    v = CW'(T_FULL);
      MORE:    v = CW'(T_MORE);
      default: v = CW'(T_LESS);
    endcase
    return v;
  endfunction

  always_comb begin
    d[0] = dec(S1);
    d[1] = dec(S2);
    d[2] = dec(S3);
    d[3] = dec(S4);
  end

  always_comb begin
    found = 1'b0;
    sel   = cur;
    idx   = cur;
    if (|E) begin
      found = 1'b1;
      for (int i = 3; i >= 0; i--) begin
        if (E[i]) sel = 2'(i);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = cur + 2'(k);
        if (!found && d[idx] != EMPTY) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end
  end

  always_comb begin
    cur_oh = 4'b0001 << cur;
    hold   = E[cur];
    el_p1  = {1'b0, el} + 1'b1;
    el_inc = (el == '1) ? el : el + 1'b1;
    pre    = (|(E & ~cur_oh)) && !hold;
    early  = (d[cur] == EMPTY) && !hold &&
             (el_p1 >= (CW+1)'(T_MIN));
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur;
    el_n    = el;
    unique case (state)
      ALL_RED: begin
        if (cnt <= 1) begin
          if (found) begin
            state_n = GREEN;
            cnt_n   = dur(d[sel]);
            cur_n   = sel;
            el_n    = '0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GREEN: begin
        // Emergency on the granted road freezes the countdown.
        if (hold) begin
          el_n = el_inc;
        end else if (pre || early || cnt <= 1) begin
          state_n = YELLOW;
          cnt_n   = CW'(T_YELLOW);
        end else begin
          cnt_n = cnt - 1'b1;
          el_n  = el_inc;
        end
      end
      YELLOW: begin
        if (cnt <= 1) begin
          state_n = ALL_RED;
          cnt_n   = CW'(T_ALLRED);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = ALL_RED;
        cnt_n   = CW'(T_ALLRED);
      end
    endcase
  end

  always_comb begin
    lt_n = L_RED;
    oh_n = 4'b0000;
    if (state_n == GREEN) begin
      lt_n = L_GRN;
      oh_n = 4'b0001 << cur_n;
    end else if (state_n == YELLOW) begin
      lt_n = L_YEL;
      oh_n = 4'b0001 << cur_n;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= ALL_RED;
      cnt   <= CW'(T_ALLRED);
      cur   <= 2'd3;
      el    <= '0;
      T     <= 4'b0000;
      T1    <= L_RED;
      T2    <= L_RED;
      T3    <= L_RED;
      T4    <= L_RED;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cur   <= cur_n;
      el    <= el_n;
      T     <= oh_n;
      T1    <= oh_n[0] ? lt_n : L_RED;
      T2    <= oh_n[1] ? lt_n : L_RED;
      T3    <= oh_n[2] ? lt_n : L_RED;
      T4    <= oh_n[3] ? lt_n : L_RED;
    end
  end

endmodule

// File: tb/tb_junction_scheduler.sv
// Directed bench for junction_scheduler: per-cycle light/one-hot
// trace checks against hand-derived phase sequences.
module tb_junction_scheduler;

  logic       clock;
  logic       clear;
  logic [2:0] S1, S2, S3, S4;
  logic [3:0] E;
  logic [1:0] T1, T2, T3, T4;
  logic [3:0] T;

  int nchk;
  int npass;

  localparam logic [2:0] EMP = 3'b000;
  localparam logic [2:0] LES = 3'b001;
  localparam logic [2:0] MOR = 3'b011;
  localparam logic [2:0] FUL = 3'b111;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  junction_scheduler dut (
    .clock (clock),
    .clear (clear),
    .S1    (S1),
    .S2    (S2),
    .S3    (S3),
    .S4    (S4),
    .E     (E),
    .T1    (T1),
    .T2    (T2),
    .T3    (T3),
    .T4    (T4),
    .T     (T)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else
      npass++;
  endtask

  function automatic logic [11:0] expv(input int road,
                                       input logic [1:0] lt);
    logic [11:0] v;
    v = '0;
    if (lt != R) begin
      v[4+2*road +: 2] = lt;
      v[road] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [11:0] obs();
    return {T4, T3, T2, T1, T};
  endfunction

  // road is 0-based; each cycle sampled on the falling edge
  task automatic phase(input string tag, input int road,
                       input logic [1:0] lt, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk(tag, 32'(obs()), 32'(expv(road, lt)));
    end
  endtask

  task automatic rst_dut();
    clear = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst", 32'(obs()), 32'h0);
    @(posedge clock);
    #1 clear = 1'b1;
  endtask

  initial begin
    nchk  = 0;
    npass = 0;
    clear = 1'b0;
    E     = 4'b0000;

    // full rotation with densities FULL, MORE, MORE, MORE
    S1 = FUL; S2 = MOR; S3 = MOR; S4 = MOR;
    rst_dut();
    phase("t1_ar0", 0, R, 1);
    phase("t1_g1",  0, G, 12);
    phase("t1_y1",  0, Y, 2);
    phase("t1_ar1", 0, R, 1);
    phase("t1_g2",  1, G, 8);
    phase("t1_y2",  1, Y, 2);
    phase("t1_ar2", 0, R, 1);
    phase("t1_g3",  2, G, 8);
    phase("t1_y3",  2, Y, 2);
    phase("t1_ar3", 0, R, 1);
    phase("t1_g4",  3, G, 8);
    phase("t1_y4",  3, Y, 2);
    phase("t1_ar4", 0, R, 1);
    phase("t1_g1b", 0, G, 2);

    // all empty idles, then a LESS road gets 4 cycles
    S1 = EMP; S2 = EMP; S3 = EMP; S4 = EMP;
    rst_dut();
    phase("t2_idle", 0, R, 20);
    S3 = LES;
    phase("t2_g3",   2, G, 4);
    phase("t2_y3",   2, Y, 2);
    phase("t2_ar",   0, R, 1);
    phase("t2_g3b",  2, G, 4);

    // empty road 2 is skipped
    S1 = MOR; S2 = EMP; S3 = MOR; S4 = MOR;
    rst_dut();
    phase("t3_ar0", 0, R, 1);
    phase("t3_g1",  0, G, 8);
    phase("t3_y1",  0, Y, 2);
    phase("t3_ar1", 0, R, 1);
    phase("t3_g3",  2, G, 8);
    phase("t3_y3",  2, Y, 2);
    phase("t3_ar3", 0, R, 1);
    phase("t3_g4",  3, G, 8);
    phase("t3_y4",  3, Y, 2);
    phase("t3_ar4", 0, R, 1);
    phase("t3_g1b", 0, G, 8);

    // early termination after T_MIN once road 1 empties
    S1 = FUL; S2 = EMP; S3 = EMP; S4 = EMP;
    rst_dut();
    phase("t4_ar0", 0, R, 1);
    phase("t4_g1a", 0, G, 1);
    S1 = EMP;
    phase("t4_g1b", 0, G, 1);
    phase("t4_y1",  0, Y, 2);
    phase("t4_idle", 0, R, 3);

    // emergency pre-emption and hold
    S1 = FUL; S2 = EMP; S3 = EMP; S4 = LES;
    rst_dut();
    phase("t5_ar0", 0, R, 1);
    phase("t5_g1",  0, G, 3);
    E = 4'b0100;
    phase("t5_y1",  0, Y, 2);
    phase("t5_ar1", 0, R, 1);
    phase("t5_hold", 2, G, 10);
    E  = 4'b0000;
    S3 = LES;
    phase("t5_rest", 2, G, 3);
    phase("t5_y3",  2, Y, 2);
    phase("t5_ar3", 0, R, 1);
    phase("t5_g4",  3, G, 4);

    // asynchronous reset mid-green restarts search at road 1
    S1 = EMP; S2 = EMP; S3 = MOR; S4 = MOR;
    E  = 4'b0000;
    rst_dut();
    phase("t6_ar0", 0, R, 1);
    phase("t6_g3",  2, G, 3);
    #1 clear = 1'b0;
    #1 chk("t6_async", 32'(obs()), 32'h0);
    S1 = MOR;
    @(posedge clock);
    #1 clear = 1'b1;
    phase("t6_ar1", 0, R, 1);
    phase("t6_g1",  0, G, 2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
